ieee754_mul_arb: RTL and testbench

IEEE754_MUL_ARB -- requirements
Module: ieee754_mul_arb

---
 rtl/ieee754_mul_arb.sv | 186 ++++++++++++++++++
 tb/tb_ieee754_mul_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ieee754_mul_arb.sv
// ieee754_mul_arb: two requesters share one IEEE 754 single-precision multiplier.
// Latency: grant in cycle T, rsp_valid first high in cycle T+MUL_LAT+1; issue interval MUL_LAT+2.
// Backpressure: the result is held in DONE until rsp_ready=1; no request is accepted until then.
// Ports: clk/rst_n (async active-low); reqN_valid/reqN_a/reqN_b/reqN_ready per requester;
//        rsp_valid/rsp_ready handshake with rsp_id (owner), rsp_s (product), rsp_ovf/rsp_unf flags.

// ieee754_mul: combinational single-precision multiply, round-to-nearest-even.
// Subnormal inputs are treated as zero; results too small for a normal are flushed to
// signed zero with UNDERFLOW, results too large saturate to infinity with OUVERFLOW.
module ieee754_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s,
  output logic        OUVERFLOW,
  output logic        UNDERFLOW
);
  logic              sgn;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0]       prod;
  logic [47:0]       prod_n;
  logic              rnd;
  logic [23:0]       man_r;
  logic signed [9:0] exp_n;

  always_comb begin
    sgn    = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);

    prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    // Normalise so the leading one sits at bit 47.
    prod_n = prod[47] ? prod : {prod[46:0], 1'b0};
    // Guard is bit 23, sticky the OR below it; ties go to an even mantissa.
    rnd    = prod_n[23] & ((|prod_n[22:0]) | prod_n[24]);
    man_r  = {1'b0, prod_n[46:24]} + {23'd0, rnd};
    // A rounding carry out of the mantissa bumps the exponent; man_r[22:0] is then zero.
    exp_n  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127
           + $signed({9'd0, prod[47]}) + $signed({9'd0, man_r[23]});

    s         = 32'd0;
    OUVERFLOW = 1'b0;
    UNDERFLOW = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      s = 32'h7fc00000;
    end else if (a_inf || b_inf) begin
      s = {sgn, 8'hff, 23'd0};
    end else if (a_zero || b_zero) begin
      s = {sgn, 31'd0};
    end else if (exp_n >= 10'sd255) begin
      s         = {sgn, 8'hff, 23'd0};
      OUVERFLOW = 1'b1;
    end else if (exp_n <= 10'sd0) begin
      s         = {sgn, 31'd0};
      UNDERFLOW = 1'b1;
    end else begin
      s = {sgn, exp_n[7:0], man_r[22:0]};
    end
  end
endmodule

module ieee754_mul_arb #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_s,
  output logic        rsp_ovf,
  output logic        rsp_unf
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        prio_q, prio_d;
  logic        id_q, id_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] rsp_s_q, rsp_s_d;
  logic        rsp_ovf_q, rsp_ovf_d;
  logic        rsp_unf_q, rsp_unf_d;

  logic        gnt0, gnt1;
  logic [31:0] mul_s;
  logic        mul_ovf, mul_unf;

  ieee754_mul u_mul (
    .a         (op_a_q),
    .b         (op_b_q),
    .s         (mul_s),
    .OUVERFLOW (mul_ovf),
    .UNDERFLOW (mul_unf)
  );

  // Requester 1 wins when it is alone or when the pointer favours it.
  assign gnt1 = (state_q == IDLE) && req1_valid && (!req0_valid || prio_q);
  assign gnt0 = (state_q == IDLE) && req0_valid && !gnt1;

  // Gated by rst_n so ready stays low while reset is held even though state reads IDLE.
  assign req0_ready = rst_n & gnt0;
  assign req1_ready = rst_n & gnt1;

  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_unf   = rsp_unf_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prio_d    = prio_q;
    id_d      = id_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    rsp_s_d   = rsp_s_q;
    rsp_ovf_d = rsp_ovf_q;
    rsp_unf_d = rsp_unf_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          id_d    = gnt1;
          op_a_d  = gnt1 ? req1_a : req0_a;
          op_b_d  = gnt1 ? req1_b : req0_b;
          cnt_d   = CNT_INIT;
          prio_d  = ~gnt1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_s_d   = mul_s;
          rsp_ovf_d = mul_ovf;
          rsp_unf_d = mul_unf;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      prio_q    <= 1'b0;
      id_q      <= 1'b0;
      op_a_q    <= 32'd0;
      op_b_q    <= 32'd0;
      rsp_s_q   <= 32'd0;
      rsp_ovf_q <= 1'b0;
      rsp_unf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prio_q    <= prio_d;
      id_q      <= id_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      rsp_s_q   <= rsp_s_d;
      rsp_ovf_q <= rsp_ovf_d;
      rsp_unf_q <= rsp_unf_d;
    end
  end
endmodule

// File: tb/tb_ieee754_mul_arb.sv
module tb_ieee754_mul_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_ovf, rsp_unf;
  logic [31:0] rsp_s;

  logic        m_req0_valid, m_req1_valid, m_rsp_ready;
  logic [31:0] m_req0_a, m_req0_b, m_req1_a, m_req1_b;
  logic        m_req0_ready, m_req1_ready, m_rsp_valid, m_rsp_id, m_rsp_ovf, m_rsp_unf;
  logic [31:0] m_rsp_s;

  ieee754_mul_arb #(.MUL_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s),
    .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf)
  );

  ieee754_mul_arb #(.MUL_LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(m_req0_valid), .req0_a(m_req0_a), .req0_b(m_req0_b), .req0_ready(m_req0_ready),
    .req1_valid(m_req1_valid), .req1_a(m_req1_a), .req1_b(m_req1_b), .req1_ready(m_req1_ready),
    .rsp_valid(m_rsp_valid), .rsp_ready(m_rsp_ready), .rsp_id(m_rsp_id), .rsp_s(m_rsp_s),
    .rsp_ovf(m_rsp_ovf), .rsp_unf(m_rsp_unf)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: real arithmetic, then IEEE single rounding ----------------
  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r * 0.5;
    return r;
  endfunction

  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] s, output logic ovf, output logic unf);
    logic        sg;
    logic [63:0] bits;
    logic [23:0] m;
    int          de;
    real         va, vb;
    bit          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    sg     = a[31] ^ b[31];
    ovf    = 1'b0;
    unf    = 1'b0;
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hff) && !a_inf;
    b_nan  = (b[30:23] == 8'hff) && !b_inf;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) s = 32'h7fc00000;
    else if (a_inf || b_inf) s = {sg, 8'hff, 23'd0};
    else if (a_zero || b_zero) s = {sg, 31'd0};
    else begin
      va   = (1.0 + real'(a[22:0]) / 8388608.0) * pow2(int'(a[30:23]) - 127);
      vb   = (1.0 + real'(b[22:0]) / 8388608.0) * pow2(int'(b[30:23]) - 127);
      // 24x24-bit product is exact in a double; round its mantissa to 23 bits, ties to even.
      bits = $realtobits(va * vb);
      de   = int'(bits[62:52]) - 896;
      m    = {1'b0, bits[51:29]} + 24'(bits[28] & ((|bits[27:0]) | bits[29]));
      if (m[23]) begin de = de + 1; m = 24'd0; end
      if (de >= 255)    begin s = {sg, 8'hff, 23'd0}; ovf = 1'b1; end
      else if (de <= 0) begin s = {sg, 31'd0};        unf = 1'b1; end
      else s = {sg, 8'(de), m[22:0]};
    end
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] f;
    f = 23'($urandom);
    case ($urandom_range(0, 9))
      0: e = 8'd0;
      1: begin e = 8'hff; if ($urandom_range(0, 1) == 0) f = 23'd0; end
      2: e = 8'($urandom_range(1, 30));
      3: e = 8'($urandom_range(225, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // ---------------- stimulus helpers (called at the sample point, #1 after negedge) ----------------
  task automatic wait_ready(input logic id, output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (id ? req1_ready : req0_ready) begin ok = 1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_rsp(output logic [34:0] got, output bit ok);
    ok  = 0;
    got = '0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin ok = 1; got = {rsp_id, rsp_ovf, rsp_unf, rsp_s}; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic do_txn(input logic id, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [34:0] got, output bit ok);
    int t0;
    lat = -1;
    got = '0;
    @(negedge clk);
    rsp_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    wait_ready(id, ok);
    t0 = cyc;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    if (!ok) return;
    wait_rsp(got, ok);
    if (ok) lat = cyc - t0;
  endtask

  task automatic apply_reset(input string name);
    @(negedge clk);
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready  = 1'b1;
    #1;
    check(name, 64'({rsp_valid, rsp_id, rsp_ovf, rsp_unf, rsp_s, req0_ready, req1_ready}), 64'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    rst_n      = 1'b1;
  endtask

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        ovf;
    logic        unf;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[12];
    logic [31:0] ms;
    logic        mo, mu, gid, e0, e1, exp_rv, prio_m, outst;
    logic [34:0] got, exp_rsp;
    logic [31:0] pa[2], pb[2];
    bit          pend[2];
    bit          ok, seen;
    int          lat, due, t0;

    tbl[0]  = '{1'b0, 32'h40400000, 32'h40800000, 32'h41400000, 1'b0, 1'b0}; // 3*4
    tbl[1]  = '{1'b1, 32'hC0400000, 32'h40800000, 32'hC1400000, 1'b0, 1'b0}; // -3*4
    tbl[2]  = '{1'b1, 32'h7F800000, 32'h40800000, 32'h7F800000, 1'b0, 1'b0}; // inf*4
    tbl[3]  = '{1'b0, 32'h00000000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0}; // 0*1
    tbl[4]  = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0}; // 1*1
    tbl[5]  = '{1'b0, 32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0}; // 2^127*2 overflows
    tbl[6]  = '{1'b1, 32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1}; // 2^-126*0.5 underflows
    tbl[7]  = '{1'b0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0}; // NaN*1
    tbl[8]  = '{1'b1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0}; // inf*0
    tbl[9]  = '{1'b0, 32'hBF800000, 32'h80000000, 32'h00000000, 1'b0, 1'b0}; // -1*-0
    tbl[10] = '{1'b1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0}; // 1.5*1.5
    tbl[11] = '{1'b0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0, 1'b0}; // inexact, rounds down

    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    m_req0_valid = 0; m_req1_valid = 0; m_rsp_ready = 0;
    m_req0_a = 0; m_req0_b = 0; m_req1_a = 0; m_req1_b = 0;

    apply_reset("reset_outputs");

    // Table: single requester, latency MUL_LAT+1, exact result and flags (V1, V4 included).
    for (int i = 0; i < 12; i++) begin
      do_txn(tbl[i].id, tbl[i].a, tbl[i].b, lat, got, ok);
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd2);
      check($sformatf("tbl%0d_rsp", i), 64'({ok, got}),
            64'({1'b1, tbl[i].id, tbl[i].ovf, tbl[i].unf, tbl[i].s}));
      ref_mul(tbl[i].a, tbl[i].b, ms, mo, mu);
      check($sformatf("tbl%0d_model", i), 64'(got), 64'({tbl[i].id, mo, mu, ms}));
    end

    // V2: contention right after reset goes to req0, then req1, then req0 again.
    apply_reset("v2_reset");
    @(negedge clk);
    req0_valid = 1; req0_a = 32'h40400000; req0_b = 32'h40800000;
    req1_valid = 1; req1_a = 32'hC0400000; req1_b = 32'h40800000;
    rsp_ready  = 1;
    #1;
    check("v2_first_grant", 64'({req0_ready, req1_ready}), 64'b10);
    @(negedge clk); req0_valid = 0; #1;
    wait_rsp(got, ok);
    check("v2_rsp0", 64'({ok, got}), 64'({1'b1, 1'b0, 2'b00, 32'h41400000}));
    wait_ready(1'b1, ok);
    check("v2_second_grant", 64'(ok), 64'd1);
    @(negedge clk); req1_valid = 0; #1;
    wait_rsp(got, ok);
    check("v2_rsp1", 64'({ok, got}), 64'({1'b1, 1'b1, 2'b00, 32'hC1400000}));
    @(negedge clk);
    req0_valid = 1; req1_valid = 1;
    #1;
    check("v2_third_grant", 64'({req0_ready, req1_ready}), 64'b10);
    @(negedge clk); req0_valid = 0; req1_valid = 0; #1;
    wait_rsp(got, ok);
    check("v2_rsp2", 64'({ok, got}), 64'({1'b1, 1'b0, 2'b00, 32'h41400000}));

    // V3: result held stable under backpressure; requests ignored while DONE.
    @(negedge clk);
    rsp_ready = 0;
    req0_valid = 1; req0_a = 32'h3F800000; req0_b = 32'h40000000;
    #1;
    wait_ready(1'b0, ok);
    @(negedge clk);
    req0_a = 32'h40400000;
    req1_valid = 1; req1_a = 32'h40400000; req1_b = 32'h40400000;
    #1;
    wait_rsp(got, ok);
    check("v3_rsp", 64'({ok, got}), 64'({1'b1, 1'b0, 2'b00, 32'h40000000}));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check($sformatf("v3_hold%0d", i),
            64'({rsp_valid, rsp_id, rsp_ovf, rsp_unf, rsp_s, req0_ready, req1_ready}),
            64'({1'b1, 1'b0, 2'b00, 32'h40000000, 2'b00}));
    end
    @(negedge clk); req0_valid = 0; req1_valid = 0; rsp_ready = 1; #1;
    @(negedge clk); #1;
    check("v3_released", 64'(rsp_valid), 64'd0);

    // V5: reset mid-BUSY after a req0 grant (pointer now at req1) drops the operation.
    @(negedge clk);
    req0_valid = 1; req0_a = 32'h40400000; req0_b = 32'h40800000;
    #1;
    wait_ready(1'b0, ok);
    check("v5_grant", 64'(ok), 64'd1);
    @(negedge clk);
    rst_n = 0; req0_valid = 1; req1_valid = 1;
    #1;
    check("v5_reset_outputs",
          64'({rsp_valid, rsp_id, rsp_ovf, rsp_unf, rsp_s, req0_ready, req1_ready}), 64'd0);
    @(negedge clk); req0_valid = 0; req1_valid = 0; rst_n = 1; #1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen = 1;
      @(negedge clk); #1;
    end
    check("v5_no_rsp", 64'(seen), 64'd0);
    req0_valid = 1; req1_valid = 1;
    #1;
    check("v5_grant_after_reset", 64'({req0_ready, req1_ready}), 64'b10);
    @(negedge clk); req0_valid = 0; req1_valid = 0; #1;
    wait_rsp(got, ok);
    check("v5_drain", 64'(ok), 64'd1);

    // V6: MUL_LAT=4 instance, latency 5.
    @(negedge clk);
    m_req0_valid = 1; m_req0_a = 32'h00000000; m_req0_b = 32'h3F800000; m_rsp_ready = 1;
    #1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_req0_ready) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    t0 = cyc;
    @(negedge clk); m_req0_valid = 0; #1;
    lat = -1;
    got = '0;
    for (int i = 0; i < 20 && ok; i++) begin
      if (m_rsp_valid) begin lat = cyc - t0; got = {m_rsp_id, m_rsp_ovf, m_rsp_unf, m_rsp_s}; break; end
      @(negedge clk); #1;
    end
    check("v6_latency", 64'(lat), 64'd5);
    check("v6_rsp", 64'(got), 64'({1'b0, 2'b00, 32'h00000000}));

    // Random traffic against the model: grants, response timing and results.
    apply_reset("rnd_reset");
    prio_m = 0; outst = 0; due = 0; exp_rsp = '0;
    pend[0] = 0; pend[1] = 0;
    pa[0] = 0; pa[1] = 0; pb[0] = 0; pb[1] = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!pend[n]) begin
          if ($urandom_range(0, 2) == 0) begin pend[n] = 1; pa[n] = rnd_op(); pb[n] = rnd_op(); end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[n] = 0;
        end
      end
      req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0];
      req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1];
      rsp_ready  = ($urandom_range(0, 3) != 0);
      #1;
      exp_rv = outst && (cyc >= due);
      e0 = 0; e1 = 0;
      if (!outst) begin
        if (pend[0] && pend[1]) begin if (prio_m) e1 = 1; else e0 = 1; end
        else if (pend[0]) e0 = 1;
        else if (pend[1]) e1 = 1;
      end
      check("rnd_ready", 64'({req0_ready, req1_ready}), 64'({e0, e1}));
      check("rnd_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv && rsp_ready) begin
        check("rnd_rsp", 64'({rsp_id, rsp_ovf, rsp_unf, rsp_s}), 64'(exp_rsp));
        outst = 0;
      end else if (e0 || e1) begin
        gid = e1;
        ref_mul(pa[gid], pb[gid], ms, mo, mu);
        exp_rsp = {gid, mo, mu, ms};
        outst   = 1;
        due     = cyc + 2;
        prio_m  = ~gid;
        pend[gid] = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
